// File: rtl/pea_1x1_mc.sv
// ROW x COL int8 MAC array for 1x1 convolution: accumulates ic_num beats per tile,
// then hands each finished tile to a valid/ready output register while the next tile accumulates.
module pea_1x1_mc #(
  parameter int ROW       = 4,
  parameter int COL       = 8,
  parameter int OFM_WIDTH = 32,
  parameter int CNT_WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  input  logic [CNT_WIDTH-1:0]         cfg_ic_num,
  input  logic [CNT_WIDTH-1:0]         cfg_tile_num,
  input  logic                         cfg_stride,
  input  logic                         cfg_relu,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [COL*8-1:0]             ifm_group,
  input  logic [ROW*8-1:0]             wgt_group,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ROW*COL*OFM_WIDTH-1:0] out_sum,
  output logic [COL-1:0]               out_mask,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACC   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [COL-1:0] STRIDE_MASK = {(COL/2){2'b01}};

  logic [1:0]                  state;
  logic [CNT_WIDTH-1:0]        ic_num_q, tile_num_q, ic_cnt, tile_cnt;
  logic                        stride_q, relu_q;
  logic signed [OFM_WIDTH-1:0] acc_p0 [ROW][COL];
  logic signed [OFM_WIDTH-1:0] sum_p0 [ROW][COL];
  logic                        vld_p1;
  logic                        last_beat, last_tile, beat, drain;

  function automatic logic signed [OFM_WIDTH-1:0] mac_fn(
    input logic signed [OFM_WIDTH-1:0] a,
    input logic signed [7:0]           x,
    input logic signed [7:0]           w
  );
    logic signed [15:0] p;
    p = x * w;
    return a + OFM_WIDTH'(p);
  endfunction

  function automatic logic signed [OFM_WIDTH-1:0] relu_fn(
    input logic signed [OFM_WIDTH-1:0] v,
    input logic                        en
  );
    return (en && v < 0) ? '0 : v;
  endfunction

  assign last_beat = (ic_cnt == ic_num_q - CNT_WIDTH'(1));
  assign last_tile = (tile_cnt == tile_num_q - CNT_WIDTH'(1));
  // Only a last beat needs the output register; it may refill it in the cycle it drains.
  assign in_ready  = (state == ACC) && !(last_beat && vld_p1 && !out_ready);
  assign beat      = in_valid && in_ready;
  assign drain     = vld_p1 && out_ready;
  assign out_valid = vld_p1;
  assign busy      = (state != IDLE);
  assign done      = (state == FLUSH) && drain && out_last;

  always_comb begin
    for (int r = 0; r < ROW; r++)
      for (int c = 0; c < COL; c++)
        sum_p0[r][c] = mac_fn(acc_p0[r][c], ifm_group[c*8 +: 8], wgt_group[r*8 +: 8]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      ic_num_q   <= '0;
      tile_num_q <= '0;
      stride_q   <= 1'b0;
      relu_q     <= 1'b0;
      ic_cnt     <= '0;
      tile_cnt   <= '0;
      vld_p1     <= 1'b0;
      out_mask   <= '0;
      out_last   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state      <= ACC;
          ic_num_q   <= (cfg_ic_num == '0) ? CNT_WIDTH'(1) : cfg_ic_num;
          tile_num_q <= (cfg_tile_num == '0) ? CNT_WIDTH'(1) : cfg_tile_num;
          stride_q   <= cfg_stride;
          relu_q     <= cfg_relu;
          ic_cnt     <= '0;
          tile_cnt   <= '0;
        end
        ACC: if (beat) begin
          if (last_beat) begin
            ic_cnt   <= '0;
            tile_cnt <= tile_cnt + CNT_WIDTH'(1);
            if (last_tile) state <= FLUSH;
          end else begin
            ic_cnt <= ic_cnt + CNT_WIDTH'(1);
          end
        end
        FLUSH: if (drain && out_last) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (beat && last_beat) begin
        vld_p1   <= 1'b1;
        out_last <= last_tile;
        out_mask <= stride_q ? STRIDE_MASK : {COL{1'b1}};
      end else if (drain) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  // Stage p0: accumulators, cleared at job start and after each tile's last beat
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      for (int r = 0; r < ROW; r++)
        for (int c = 0; c < COL; c++)
          acc_p0[r][c] <= '0;
    end else if (beat) begin
      for (int r = 0; r < ROW; r++)
        for (int c = 0; c < COL; c++)
          acc_p0[r][c] <= last_beat ? '0 : sum_p0[r][c];
    end
  end

  // Stage p1: output register, written with the final sum of each tile
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_sum <= '0;
    end else if (beat && last_beat) begin
      for (int r = 0; r < ROW; r++)
        for (int c = 0; c < COL; c++)
          out_sum[(r*COL+c)*OFM_WIDTH +: OFM_WIDTH] <= relu_fn(sum_p0[r][c], relu_q);
    end
  end

endmodule

// File: tb/tb_pea_1x1_mc.sv
// Randomized self-checking bench for pea_1x1_mc against a tile-level arithmetic model.
module tb_pea_1x1_mc;
  localparam int ROW = 4;
  localparam int COL = 8;
  localparam int W   = 32;
  localparam int CW  = 10;
  localparam int SW  = ROW*COL*W;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           start = 1'b0;
  logic [CW-1:0]  cfg_ic_num = '0;
  logic [CW-1:0]  cfg_tile_num = '0;
  logic           cfg_stride = 1'b0;
  logic           cfg_relu = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [COL*8-1:0] ifm_group = '0;
  logic [ROW*8-1:0] wgt_group = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [SW-1:0]  out_sum;
  logic [COL-1:0] out_mask;
  logic           out_last, busy, done;

  pea_1x1_mc #(.ROW(ROW), .COL(COL), .OFM_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .cfg_ic_num(cfg_ic_num),
    .cfg_tile_num(cfg_tile_num), .cfg_stride(cfg_stride), .cfg_relu(cfg_relu),
    .in_valid(in_valid), .in_ready(in_ready), .ifm_group(ifm_group), .wgt_group(wgt_group),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_mask(out_mask),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SW-1:0]  sum;
    logic [COL-1:0] mask;
    logic           last;
  } exp_t;

  exp_t expq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  int   rdy_mode = 1;  // 0: hold low, 1: hold high, 2: random

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(act), $signed(exp));
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Scoreboard: every accepted tile is compared with the oldest expected tile.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rstn && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        check("unexpected_tile", 64'(expq.size()), 64'd1);
      end else begin
        e = expq.pop_front();
        for (int i = 0; i < ROW*COL; i++)
          check("sum", 64'($signed(out_sum[i*W +: W])), 64'($signed(e.sum[i*W +: W])));
        check("mask", 64'(out_mask), 64'(e.mask));
        check("last", 64'(out_last), 64'(e.last));
        check("done", 64'(done), 64'(e.last));
      end
    end
    if (rstn && done) done_cnt++;
  end

  task automatic send_beat(input logic [COL*8-1:0] f, input logic [ROW*8-1:0] w, output int waited);
    int n;
    n = 0;
    in_valid  = 1'b1;
    ifm_group = f;
    wgt_group = w;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (n >= 500) check("beat_timeout", 64'(n), 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    waited = n;
  endtask

  task automatic run_job(input int ic, input int tn, input logic st, input logic rl,
                         input bit rnd, input logic [7:0] fv, input logic [7:0] wv,
                         input int gap_max, input int hold, output int stalls);
    int ic_e, tn_e, d0, waited, t_out, v;
    int acc [ROW][COL];
    exp_t e;
    logic [COL*8-1:0] f;
    logic [ROW*8-1:0] w;
    ic_e = (ic == 0) ? 1 : ic;
    tn_e = (tn == 0) ? 1 : tn;
    d0 = done_cnt;
    stalls = 0;
    cfg_ic_num = CW'(ic);
    cfg_tile_num = CW'(tn);
    cfg_stride = st;
    cfg_relu = rl;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("start_in_ready", 64'(in_ready), 64'd1);
    check("start_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    for (int t = 0; t < tn_e; t++) begin
      for (int r = 0; r < ROW; r++)
        for (int c = 0; c < COL; c++)
          acc[r][c] = 0;
      for (int b = 0; b < ic_e; b++) begin
        for (int c = 0; c < COL; c++) f[c*8 +: 8] = rnd ? 8'($urandom) : fv;
        for (int r = 0; r < ROW; r++) w[r*8 +: 8] = rnd ? 8'($urandom) : wv;
        for (int r = 0; r < ROW; r++)
          for (int c = 0; c < COL; c++)
            acc[r][c] += int'($signed(f[c*8 +: 8])) * int'($signed(w[r*8 +: 8]));
        if (b == ic_e - 1) begin
          for (int r = 0; r < ROW; r++)
            for (int c = 0; c < COL; c++) begin
              v = (rl && acc[r][c] < 0) ? 0 : acc[r][c];
              e.sum[(r*COL+c)*W +: W] = v;
            end
          for (int c = 0; c < COL; c++) e.mask[c] = st ? (c % 2 == 0) : 1'b1;
          e.last = (t == tn_e - 1);
          expq.push_back(e);
        end
        if (hold > 0 && t == 1 && b == ic_e - 1) begin
          in_valid = 1'b1;
          ifm_group = f;
          wgt_group = w;
          for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("hold_valid", 64'(out_valid), 64'd1);
            @(posedge clk);
            #1;
            start = (k == 0);
            cfg_ic_num = CW'(1);
          end
          start = 1'b0;
          rdy_mode = 1;
        end
        send_beat(f, w, waited);
        stalls += waited;
        repeat ($urandom_range(0, gap_max)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    t_out = 0;
    @(negedge clk);
    while (busy && t_out < 2000) begin
      @(negedge clk);
      t_out++;
    end
    if (t_out >= 2000) check("job_timeout", 64'(t_out), 64'd0);
    check("queue_empty", 64'(expq.size()), 64'd0);
    check("done_once", 64'(done_cnt - d0), 64'd1);
    check("idle_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int s;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_sum", 64'(|out_sum), 64'd0);
    check("rst_out_mask", 64'(out_mask), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    rdy_mode = 1;
    run_job(3, 1, 1'b0, 1'b0, 1'b0, 8'd2, 8'd3, 0, 0, s);
    run_job(4, 1, 1'b0, 1'b0, 1'b0, 8'h80, 8'h80, 0, 0, s);
    run_job(4, 1, 1'b1, 1'b1, 1'b0, 8'h80, 8'd127, 0, 0, s);
    run_job(4, 1, 1'b0, 1'b0, 1'b0, 8'h80, 8'd127, 0, 0, s);

    rdy_mode = 0;
    run_job(2, 3, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 0, 10, s);

    rdy_mode = 1;
    run_job(1, 5, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 0, 0, s);
    check("b2b_stalls", 64'(s), 64'd0);

    rdy_mode = 2;
    for (int j = 0; j < 8; j++)
      run_job($urandom_range(0, 5), $urandom_range(0, 4), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'b1, 8'd0, 8'd0, 2, 0, s);

    // Abort a job with a full output register and a half-accumulated tile.
    rdy_mode = 0;
    cfg_ic_num = CW'(4);
    cfg_tile_num = CW'(2);
    cfg_stride = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int b = 0; b < 6; b++) send_beat({$urandom, $urandom}, $urandom, s);
    @(negedge clk);
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_sum", 64'(|out_sum), 64'd0);
    check("mid_rst_mask", 64'(out_mask), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    rdy_mode = 1;
    @(posedge clk);
    #1;
    run_job(4, 1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 0, 0, s);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
